// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V fetch slice.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // Sequencer states of the IF stage.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Sources of the next program counter.
  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2,
    PC_TRAP     = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/if_pc_sel.sv
// Combinational next-PC mux: hold, sequential +4, redirect target or trap vector.
// Redirect targets are always word-aligned here; misaligned targets are
// steered to PC_TRAP by the caller when trapping is enabled.
module if_pc_sel import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [1:0]      i_sel,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc_next,
  output logic [XLEN-1:0] o_pc_inc
);

  // Sequential successor; wraps modulo 2^32.
  assign o_pc_inc = i_pc + 32'd4;

  // Select the next PC from the requested source.
  always_comb begin
    o_pc_next = i_pc;
    case (pc_sel_t'(i_sel))
      PC_HOLD:     o_pc_next = i_pc;
      PC_INC:      o_pc_next = o_pc_inc;
      PC_REDIRECT: o_pc_next = i_redirect_pc & ~32'd3;
      PC_TRAP:     o_pc_next = TRAP_VECTOR;
      default:     o_pc_next = i_pc;
    endcase
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: owns the PC, runs the imem req/ack handshake, buffers one
// instruction during stalls and presents {pc, pc4, inst, valid} to IF/ID.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect -> TRAP_VECTOR).
module if_fetch_ctrl import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0200,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        fetch_misalign
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_drop_addr;
  logic [31:0]  r_skid_pc;
  logic [31:0]  r_skid_inst;
  logic         r_if_valid;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_pc4;
  logic [31:0]  r_if_inst;
  logic         r_misalign;

  logic         w_misalign;
  logic [1:0]   w_pc_sel;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_pc_inc;

  // Decide where the PC goes next: redirect beats everything, ack in REQ advances.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_misalign = 1'b0;
    w_pc_sel   = PC_HOLD;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    w_misalign = 1'b0;
`endif
    if (redirect_valid)
      w_pc_sel = w_misalign ? PC_TRAP : PC_REDIRECT;
    else if ((r_state == REQ) && imem_ack)
      w_pc_sel = PC_INC;
  end

  if_pc_sel #(.TRAP_VECTOR(TRAP_VECTOR)) u_pc_sel (
    .i_sel         (w_pc_sel),
    .i_pc          (r_pc),
    .i_redirect_pc (redirect_pc),
    .o_pc_next     (w_pc_next),
    .o_pc_inc      (w_pc_inc)
  );

  // DROP keeps presenting the pre-redirect address until its ack arrives.
  assign imem_req       = (r_state == REQ) || (r_state == DROP);
  assign imem_addr      = (r_state == DROP) ? r_drop_addr : r_pc;
  assign if_valid       = r_if_valid;
  assign if_pc          = r_if_pc;
  assign if_pc4         = r_if_pc4;
  assign if_inst        = r_if_inst;
  assign fetch_misalign = r_misalign;

  // Fetch FSM with skid buffer and registered IF/ID outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= BOOT;
      r_pc        <= RESET_VECTOR;
      r_drop_addr <= '0;
      // NOTE: the skid register is reset too, so it never holds X even though it is only read after a write.
      r_skid_pc   <= '0;
      r_skid_inst <= NOP_INST;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_pc4    <= 32'd4;
      r_if_inst   <= NOP_INST;
      r_misalign  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_pc       <= w_pc_next;
      r_misalign <= w_misalign;
      if (redirect_valid) begin
        // Flush: drop whatever was presented or buffered; ack data this cycle is discarded.
        r_if_valid  <= 1'b0;
        r_if_inst   <= NOP_INST;
        r_skid_inst <= NOP_INST;
        case (r_state)
          REQ: begin
            if (!imem_ack) begin
              r_state     <= DROP;
              r_drop_addr <= r_pc;
            end
          end
          DROP: begin
            if (imem_ack) r_state <= REQ;
          end
          default: r_state <= REQ;
        endcase
      end else begin
        case (r_state)
          BOOT: r_state <= REQ;
          REQ: begin
            if (imem_ack && !stall_i) begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_pc4   <= w_pc_inc;
              r_if_inst  <= imem_rdata;
            end else if (imem_ack) begin
              r_skid_pc   <= r_pc;
              r_skid_inst <= imem_rdata;
              r_state     <= HOLD;
            end else if (!stall_i) begin
              r_if_valid <= 1'b0;
              r_if_inst  <= NOP_INST;
            end
          end
          HOLD: begin
            if (!stall_i) begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_skid_pc;
              r_if_pc4   <= r_skid_pc + 32'd4;
              r_if_inst  <= r_skid_inst;
              r_state    <= REQ;
            end
          end
          DROP: begin
            if (imem_ack) r_state <= REQ;
          end
          default: r_state <= BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl. Memory model: rdata = addr + 0x1000_0000,
// driven at the negedge so ack can coincide with req (zero-wait).
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] OFS = 32'h1000_0000;

  logic        clock;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        fetch_misalign;

  int n_cmp;
  int n_err;

  if_fetch_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .if_inst        (if_inst),
    .fetch_misalign (fetch_misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic [31:0] inst);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    check({tag, ".pc"},    if_pc,   pc);
    check({tag, ".pc4"},   if_pc4,  pc4);
    check({tag, ".inst"},  if_inst, inst);
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) check({tag, ".addr"}, imem_addr, addr);
  endtask

  // One clock: drive inputs at the negedge, return 1 time unit after the posedge.
  task automatic cyc(input logic ack, input logic stall, input logic rv, input logic [31:0] rpc);
    @(negedge clock);
    imem_ack       = ack;
    stall_i        = stall;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdata     = imem_addr + OFS;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    stall_i = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_ack = 1'b0;
    imem_rdata = '0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk_req("rst", 1'b0, 32'h0);
    chk_out("rst", 1'b0, 32'h0, 32'h4, NOP);
    check("rst.misalign", {31'd0, fetch_misalign}, 32'd0);
    check("rst.addr", imem_addr, 32'h200);

    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_req("boot", 1'b1, 32'h200);
    check("boot.valid", {31'd0, if_valid}, 32'd0);

    // 1: zero-wait memory
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("zw0", 1'b1, 32'h200, 32'h204, 32'h1000_0200);
    chk_req("zw0", 1'b1, 32'h204);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("zw1", 1'b1, 32'h204, 32'h208, 32'h1000_0204);
    chk_req("zw1", 1'b1, 32'h208);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("zw2", 1'b1, 32'h208, 32'h20C, 32'h1000_0208);
    chk_req("zw2", 1'b1, 32'h20C);

    // 2: two-cycle latency, one bubble per fetch
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("lat0", 1'b0, 32'h208, 32'h20C, NOP);
    chk_req("lat0", 1'b1, 32'h20C);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("lat1", 1'b1, 32'h20C, 32'h210, 32'h1000_020C);
    chk_req("lat1", 1'b1, 32'h210);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("lat2.valid", {31'd0, if_valid}, 32'd0);
    chk_req("lat2", 1'b1, 32'h210);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("lat3", 1'b1, 32'h210, 32'h214, 32'h1000_0210);
    chk_req("lat3", 1'b1, 32'h214);

    // 3: stall for 3 cycles as the ack arrives
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk_out("st0", 1'b1, 32'h210, 32'h214, 32'h1000_0210);
    chk_req("st0", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk_out("st1", 1'b1, 32'h210, 32'h214, 32'h1000_0210);
    chk_req("st1", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk_out("st2", 1'b1, 32'h210, 32'h214, 32'h1000_0210);
    chk_req("st2", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("st3", 1'b1, 32'h214, 32'h218, 32'h1000_0214);
    chk_req("st3", 1'b1, 32'h218);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("st4", 1'b1, 32'h218, 32'h21C, 32'h1000_0218);
    chk_req("st4", 1'b1, 32'h21C);

    // 4: redirect while a request is waiting -> DROP
    cyc(1'b0, 1'b0, 1'b1, 32'h400);
    check("dr0.valid", {31'd0, if_valid}, 32'd0);
    check("dr0.inst", if_inst, NOP);
    chk_req("dr0", 1'b1, 32'h21C);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("dr1.valid", {31'd0, if_valid}, 32'd0);
    chk_req("dr1", 1'b1, 32'h21C);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("dr2.valid", {31'd0, if_valid}, 32'd0);
    check("dr2.inst", if_inst, NOP);
    chk_req("dr2", 1'b1, 32'h400);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("dr3", 1'b1, 32'h400, 32'h404, 32'h1000_0400);
    chk_req("dr3", 1'b1, 32'h404);

    // 5: redirect to the top of the address space, ack in the same cycle
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wr0.valid", {31'd0, if_valid}, 32'd0);
    chk_req("wr0", 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("wr1", 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0FFF_FFFC);
    chk_req("wr1", 1'b1, 32'h0000_0000);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("wr2", 1'b1, 32'h0000_0000, 32'h0000_0004, 32'h1000_0000);
    chk_req("wr2", 1'b1, 32'h0000_0004);

    // 6: reset mid-request, then misaligned redirect
    @(negedge clock);
    imem_ack = 1'b0;
    stall_i = 1'b0;
    redirect_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk_req("mrst", 1'b0, 32'h0);
    chk_out("mrst", 1'b0, 32'h0, 32'h4, NOP);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_req("mboot", 1'b1, 32'h200);

    cyc(1'b1, 1'b0, 1'b1, 32'h402);
    check("mis0.valid", {31'd0, if_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis0.pulse", {31'd0, fetch_misalign}, 32'd1);
    chk_req("mis0", 1'b1, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("mis1.pulse", {31'd0, fetch_misalign}, 32'd0);
    chk_out("mis1", 1'b1, 32'h100, 32'h104, 32'h1000_0100);
`else
    check("mis0.pulse", {31'd0, fetch_misalign}, 32'd0);
    chk_req("mis0", 1'b1, 32'h400);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("mis1.pulse", {31'd0, fetch_misalign}, 32'd0);
    chk_out("mis1", 1'b1, 32'h400, 32'h404, 32'h1000_0400);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
